// File: rtl/fifo_top.sv
// fifo_top: single-clock FIFO with registered read data and registered full/empty flags
// Ports: clk, rst_n (async, active-low); wr_en/din/full on the write side;
//        rd_en/dout/empty on the read side. dout is updated one edge after an accepted read.
module fifo_top #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_add, rd_add;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic full_q, full_d, empty_q, empty_d;
    logic wr_acc, rd_acc;
    assign wr_add = wr_ptr_q[AW-1:0];
    assign rd_add = rd_ptr_q[AW-1:0];
    // The extra pointer MSB tells a full ring (same address, laps differ) from an empty one.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        dout_d   = rd_acc ? mem[rd_add] : dout_q;
        empty_d  = wr_ptr_d == rd_ptr_d;
        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_add] <= din;
    end
    assign full  = full_q;
    assign empty = empty_q;
    assign dout  = dout_q;
endmodule

// File: tb/tb_fifo_top.sv
// tb_fifo_top: queue-model self-checking bench for fifo_top
module tb_fifo_top;
    localparam int D = 8;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [W-1:0] din = '0;
    logic full, empty;
    logic [W-1:0] dout;
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    int m_wcnt = 0;
    int n_cmp = 0;
    int n_fail = 0;
    bit saw_full;

    fifo_top #(.FIFO_DEPTH(D), .FIFO_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(full),
        .rd_en(rd_en), .dout(dout), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout = '0;
        m_wcnt = 0;
    endtask

    // Checks the DUT against the queue model; called once per cycle at the falling edge.
    task automatic compare_all();
        chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
        chk("full", {31'b0, full}, {31'b0, q.size() == D});
        chk("dout", {16'b0, dout}, {16'b0, m_dout});
        chk("wr_add", {29'b0, dut.wr_add}, 32'(m_wcnt % D));
        if (full) saw_full = 1'b1;
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        bit wa, ra;
        wr_en = w;
        rd_en = r;
        din = d;
        @(posedge clk);
        wa = w && q.size() < D;
        ra = r && q.size() > 0;
        if (ra) m_dout = q.pop_front();
        if (wa) begin
            q.push_back(d);
            m_wcnt++;
        end
        @(negedge clk);
        compare_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            compare_all();
        end
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_dout", {16'b0, dout}, 32'd0);
        rst_n = 1'b1;
        // fill
        for (int i = 0; i < D; i++) begin
            chk("fill_not_full", {31'b0, full}, 32'd0);
            step(1'b1, 1'b0, W'(16'hA000 + i));
        end
        chk("fill_full", {31'b0, full}, 32'd1);
        step(1'b1, 1'b0, 16'hDEAD);
        chk("ovf_full", {31'b0, full}, 32'd1);
        chk("ovf_wr_add", {29'b0, dut.wr_add}, 32'd0);
        // drain
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_dout", {16'b0, dout}, 32'(16'hA000 + i));
        end
        chk("drain_empty", {31'b0, empty}, 32'd1);
        step(1'b0, 1'b1, '0);
        chk("udf_dout_held", {16'b0, dout}, 32'h0000A007);
        // concurrent: 20 writes overlapped with 20 reads
        for (int i = 0; i <= 20; i++) step(i < 20, i > 0, W'(16'hC000 + 3 * i));
        chk("conc_last", {16'b0, dout}, 32'(16'hC000 + 57));
        chk("conc_empty", {31'b0, empty}, 32'd1);
        // wrap-around
        saw_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) step(1'b1, 1'b0, W'(16'h7000 + 16 * k + i));
            for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
        end
        chk("wrap_last", {16'b0, dout}, 32'h00007026);
        chk("wrap_never_full", {31'b0, saw_full}, 32'd0);
        chk("wrap_empty", {31'b0, empty}, 32'd1);
        // mid-operation reset
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(16'hBB00 + i));
        chk("mid_pre_empty", {31'b0, empty}, 32'd0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_empty", {31'b0, empty}, 32'd1);
        chk("mid_rst_full", {31'b0, full}, 32'd0);
        chk("mid_rst_dout", {16'b0, dout}, 32'd0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h5A5A);
        step(1'b0, 1'b1, '0);
        chk("mid_new_word", {16'b0, dout}, 32'h00005A5A);
        chk("mid_end_empty", {31'b0, empty}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
